auto_play: RTL and testbench

- Stand-alone song player for the keyboard.
- Reads a fixed per-song note ROM, steps through it at a fixed beat rate, and drives a square-wave speaker output at the current note's pitch.
- The pitch is shifted by the octave keys.
- Exposes the current note code so the display/LED logic can show it.

---
 rtl/auto_play.sv | 202 ++++++++++++++++++++
 tb/tb_auto_play.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/auto_play.sv
// auto_play: ROM-driven song player with a square-wave speaker output.
// Define AUTOPLAY_LOOP_EN to wrap at the end marker instead of stopping.
module auto_play #(
  parameter int CLK_HZ     = 100000000,
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] selected_song,
  input  logic [1:0] octave_keys,
  output logic [3:0] note_out,
  output logic       speaker
);

  localparam int HW = $clog2(CLK_HZ) + 1;
  localparam int DW = $clog2(4 * NOTE_TICKS + 1);
  localparam logic [DW-1:0] NT   = DW'(NOTE_TICKS);
  localparam logic [DW-1:0] GAP1 = DW'(GAP_TICKS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t        r_state, w_state;
  logic [4:0]    r_idx, w_idx;
  logic [DW-1:0] r_rem, w_rem;
  logic [HW-1:0] r_pcnt, w_pcnt;
  logic [HW-1:0] r_half, w_half;
  logic          r_spk, w_spk;
  logic [3:0]    r_note, w_note;
  logic [3:0]    r_song;
  logic          w_valid;
  logic          w_ld;
  logic [4:0]    w_ld_idx;
  logic [5:0]    w_ent;

  // Entry format {note, beats}; note 15 ends the song, beats 0 means 4.
  function automatic logic [5:0] f_rom(input logic [3:0] s,
                                       input logic [4:0] i);
    logic [5:0] e;
    e = {4'hF, 2'd0};
    case (s)
      4'd1:
        case (i)
          5'd0:  e = {4'd1, 2'd1};
          5'd1:  e = {4'd1, 2'd1};
          5'd2:  e = {4'd5, 2'd1};
          5'd3:  e = {4'd5, 2'd1};
          5'd4:  e = {4'd6, 2'd1};
          5'd5:  e = {4'd6, 2'd1};
          5'd6:  e = {4'd5, 2'd2};
          5'd7:  e = {4'd4, 2'd1};
          5'd8:  e = {4'd4, 2'd1};
          5'd9:  e = {4'd3, 2'd1};
          5'd10: e = {4'd3, 2'd1};
          5'd11: e = {4'd2, 2'd1};
          5'd12: e = {4'd2, 2'd1};
          5'd13: e = {4'd1, 2'd2};
          default: e = {4'hF, 2'd0};
        endcase
      4'd2:
        if (i < 5'd7) e = {4'(i + 5'd1), 2'd1};
      4'd3:
        case (i)
          5'd0: e = {4'd5, 2'd2};
          5'd1: e = {4'd0, 2'd1};
          5'd2: e = {4'd5, 2'd2};
          5'd3: e = {4'd3, 2'd0};
          default: e = {4'hF, 2'd0};
        endcase
      4'd4:
        if (i < 5'd7) e = {4'(5'd7 - i), 2'd1};
      default: e = {4'hF, 2'd0};
    endcase
    return e;
  endfunction

  function automatic logic [DW-1:0] f_dur(input logic [1:0] b);
    case (b)
      2'd1:    return NT;
      2'd2:    return NT << 1;
      2'd3:    return NT + (NT << 1);
      default: return NT << 2;
    endcase
  endfunction

  function automatic logic [HW-1:0] f_half(input logic [3:0] n,
                                           input logic [1:0] o);
    logic [HW-1:0] b;
    case (n)
      4'd2:    b = HW'(CLK_HZ / (2 * 294));
      4'd3:    b = HW'(CLK_HZ / (2 * 330));
      4'd4:    b = HW'(CLK_HZ / (2 * 349));
      4'd5:    b = HW'(CLK_HZ / (2 * 392));
      4'd6:    b = HW'(CLK_HZ / (2 * 440));
      4'd7:    b = HW'(CLK_HZ / (2 * 494));
      default: b = HW'(CLK_HZ / (2 * 262));
    endcase
    case (o)
      2'b01:   return b >> 1;
      2'b10:   return b << 1;
      default: return b;
    endcase
  endfunction

  assign w_valid = (selected_song != 4'd0) && (selected_song <= 4'd4);

  always_comb begin
    w_ld     = 1'b0;
    w_ld_idx = 5'd0;
    if (w_valid) begin
      if (selected_song != r_song || r_state == IDLE) begin
        w_ld = 1'b1;
      end else if ((r_state == PLAY || r_state == GAP)
                   && r_rem == DW'(1)) begin
        w_ld     = 1'b1;
        w_ld_idx = r_idx + 5'd1;
      end
    end
    w_ent = f_rom(selected_song, w_ld_idx);
`ifdef AUTOPLAY_LOOP_EN
    if (w_ent[5:2] == 4'hF) begin
      w_ld_idx = 5'd0;
      w_ent    = f_rom(selected_song, 5'd0);
    end
`endif
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_rem   = r_rem;
    w_pcnt  = r_pcnt;
    w_half  = r_half;
    w_spk   = r_spk;
    w_note  = r_note;
    if (!w_valid) begin
      w_state = IDLE;
      w_idx   = 5'd0;
      w_rem   = '0;
      w_pcnt  = '0;
      w_spk   = 1'b0;
      w_note  = 4'd0;
    end else if (w_ld && w_ent[5:2] == 4'hF) begin
      w_state = DONE;
      w_idx   = w_ld_idx;
      w_rem   = '0;
      w_pcnt  = '0;
      w_spk   = 1'b0;
      w_note  = 4'd0;
    end else if (w_ld) begin
      w_state = PLAY;
      w_idx   = w_ld_idx;
      w_rem   = f_dur(w_ent[1:0]);
      w_pcnt  = '0;
      w_spk   = 1'b0;
      w_note  = w_ent[5:2];
      w_half  = f_half(w_ent[5:2], octave_keys);
    end else if (r_state == PLAY || r_state == GAP) begin
      w_rem = r_rem - DW'(1);
      if (r_rem <= GAP1) begin
        w_state = GAP;
        w_pcnt  = '0;
        w_spk   = 1'b0;
      end else if (r_note == 4'd0) begin
        w_spk = 1'b0;
      end else if (r_pcnt == r_half - HW'(1)) begin
        // The octave is only re-sampled here so a half-cycle is never cut.
        w_spk  = ~r_spk;
        w_pcnt = '0;
        w_half = f_half(r_note, octave_keys);
      end else begin
        w_pcnt = r_pcnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
      r_rem   <= '0;
      r_pcnt  <= '0;
      r_half  <= '0;
      r_spk   <= 1'b0;
      r_note  <= 4'd0;
      r_song  <= 4'd0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_rem   <= w_rem;
      r_pcnt  <= w_pcnt;
      r_half  <= w_half;
      r_spk   <= w_spk;
      r_note  <= w_note;
      r_song  <= selected_song;
    end
  end

  assign note_out = r_note;
  assign speaker  = r_spk;

endmodule

// File: tb/tb_auto_play.sv
// tb_auto_play: scoreboard bench for auto_play.
// Expected note/speaker values are queued by cycle and checked by a monitor.
module tb_auto_play;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] selected_song;
  logic [1:0] octave_keys;
  logic [3:0] note_out;
  logic       speaker;

  always #5 clk = ~clk;

  auto_play #(
    .CLK_HZ(1000000),
    .NOTE_TICKS(1000),
    .GAP_TICKS(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .selected_song(selected_song),
    .octave_keys(octave_keys),
    .note_out(note_out),
    .speaker(speaker)
  );

  typedef struct {
    int    cyc;
    int    note;
    int    spk;
    string name;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // spk < 0 means the speaker level is not checked at that cycle
  task automatic chk(input int c, input int n, input int s,
                     input string nm);
    exp_t e;
    e.cyc  = c;
    e.note = n;
    e.spk  = s;
    e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      checks = checks + 1;
      if (m_e.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: check at cycle %0d missed (now %0d)",
                 m_e.name, m_e.cyc, cyc);
      end else if (note_out !== 4'(m_e.note)
                   || (m_e.spk >= 0 && speaker !== 1'(m_e.spk))) begin
        errors = errors + 1;
        $display("FAIL %s @%0d: got note_out=%0d speaker=%b, want note_out=%0d speaker=%0d",
                 m_e.name, cyc, note_out, speaker, m_e.note, m_e.spk);
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset(output int t0);
    reset = 1'b1;
    chk(cyc + 5, 0, 0, "reset_state");
    repeat (10) @(negedge clk);
    reset = 1'b0;
    t0 = cyc + 1;
  endtask

  initial begin
    int t;
    int t2;
    reset         = 1'b1;
    selected_song = 4'd1;
    octave_keys   = 2'b00;
    @(negedge clk);

    do_reset(t);
    chk(t + 0,    1, 0, "first_note");
    chk(t + 500,  1, 0, "c4_half_1908");
    chk(t + 899,  1, 0, "c4_last_play");
    chk(t + 900,  1, 0, "gap_note_held");
    chk(t + 1000, 1, 0, "second_c4");
    chk(t + 1999, 1, 0, "c4_end");
    chk(t + 2000, 5, 0, "g4_at_2000");
    chk(t + 3999, 5, 0, "g4_gap");
    chk(t + 4000, 6, 0, "a4_up_start");
    chk(t + 4567, 6, 0, "a4_up_before");
    chk(t + 4568, 6, 1, "a4_up_568");
    chk(t + 4899, 6, 1, "a4_up_high");
    chk(t + 4900, 6, 0, "a4_up_gap");
    chk(t + 5000, 6, 0, "a4_down_start");
    chk(t + 5568, 6, 0, "a4_down_2272");
    chk(t + 6000, 5, 0, "g4_long_start");
    chk(t + 7274, 5, 0, "g4_half_kept");
    chk(t + 7275, 5, 1, "g4_toggle");
    chk(t + 7899, 5, 1, "g4_new_half");
    chk(t + 7900, 5, 0, "g4_long_gap");
    chk(t + 8000, 4, 0, "f4_start");
    chk(t + 8715, 4, 0, "f4_up_before");
    chk(t + 8716, 4, 1, "f4_up_716");
    chk(t + 15999, 1, -1, "last_c4");
`ifdef AUTOPLAY_LOOP_EN
    chk(t + 16000, 1, 0, "loop_wrap");
    chk(t + 18000, 5, 0, "loop_g4");
`else
    chk(t + 16000, 0, 0, "done_enter");
    chk(t + 18000, 0, 0, "done_hold");
    chk(t + 21000, 0, 0, "done_5000");
`endif
    goto(t + 3500);
    octave_keys = 2'b01;
    goto(t + 4950);
    octave_keys = 2'b10;
    goto(t + 5500);
    octave_keys = 2'b00;
    goto(t + 6700);
    octave_keys = 2'b01;
    goto(t + 21001);

    octave_keys = 2'b00;
    do_reset(t);
    chk(t + 0,    1, 0, "sw_first");
    chk(t + 3500, 5, 0, "sw_before");
    chk(t + 3501, 0, 0, "sw_idle");
    chk(t + 3550, 0, 0, "sw_idle_hold");
    chk(t + 3601, 1, 0, "sw_restart");
    chk(t + 5600, 1, 0, "sw_restart_c4");
    chk(t + 5601, 5, 0, "sw_restart_g4");
    goto(t + 3500);
    selected_song = 4'd0;
    goto(t + 3600);
    selected_song = 4'd1;
    goto(t + 5602);

    octave_keys = 2'b01;
    do_reset(t);
    t2 = t + 5511;
    chk(t + 0,    1, 0, "rst_first");
    chk(t + 2636, 5, 0, "rst_g4_before");
    chk(t + 2637, 5, 1, "rst_g4_637");
    chk(t + 5500, 6, 0, "rst_before");
    chk(t + 5501, 0, 0, "rst_clear");
    chk(t + 5509, 0, 0, "rst_held");
    chk(t2 + 0,    1, 0, "rst_restart");
    chk(t2 + 2000, 5, 0, "rst_restart_g4");
    goto(t + 5500);
    reset = 1'b1;
    goto(t + 5510);
    reset = 1'b0;
    goto(t2 + 2001);

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL pending: %0d checks never reached, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
